// File: rtl/tdm_demux4.sv
// rtl/tdm_demux4.sv - 4-slot TDM demultiplexer with sync-strobe framing
// Rebuilds four parallel channels from a slot-0-flagged TDM beat stream.
module tdm_demux4 #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  input  logic             sync,
  output logic [WIDTH-1:0] ch0,
  output logic [WIDTH-1:0] ch1,
  output logic [WIDTH-1:0] ch2,
  output logic [WIDTH-1:0] ch3,
  output logic             frame_valid,
  output logic             sync_err,
  output logic             locked,
  output logic [CNT_W-1:0] frame_count
);

  typedef enum logic {HUNT = 1'b0, LOCKED = 1'b1} state_t;

  state_t           state_q;
  logic [1:0]       slot_q;
  logic [WIDTH-1:0] shadow0_q, shadow1_q, shadow2_q;
  logic [WIDTH-1:0] ch0_q, ch1_q, ch2_q, ch3_q;
  logic             frame_valid_q, sync_err_q;
  logic [CNT_W-1:0] frame_count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= HUNT;
      slot_q        <= 2'd0;
      shadow0_q     <= '0;
      shadow1_q     <= '0;
      shadow2_q     <= '0;
      ch0_q         <= '0;
      ch1_q         <= '0;
      ch2_q         <= '0;
      ch3_q         <= '0;
      frame_valid_q <= 1'b0;
      sync_err_q    <= 1'b0;
      frame_count_q <= '0;
    end else begin
      frame_valid_q <= 1'b0;
      sync_err_q    <= 1'b0;
      if (din_valid) begin
        unique case (state_q)
          HUNT: begin
            if (sync) begin
              shadow0_q <= din;
              slot_q    <= 2'd1;
              state_q   <= LOCKED;
            end
          end
          LOCKED: begin
            if (sync) begin
              // A sync on slot 1-3 abandons the partial frame and restarts here.
              if (slot_q != 2'd0) sync_err_q <= 1'b1;
              shadow0_q <= din;
              slot_q    <= 2'd1;
            end else begin
              unique case (slot_q)
                2'd0: begin
                  sync_err_q <= 1'b1;
                  state_q    <= HUNT;
                  slot_q     <= 2'd0;
                end
                2'd1: begin
                  shadow1_q <= din;
                  slot_q    <= 2'd2;
                end
                2'd2: begin
                  shadow2_q <= din;
                  slot_q    <= 2'd3;
                end
                2'd3: begin
                  ch0_q         <= shadow0_q;
                  ch1_q         <= shadow1_q;
                  ch2_q         <= shadow2_q;
                  ch3_q         <= din;
                  frame_valid_q <= 1'b1;
                  frame_count_q <= frame_count_q + 1'b1;
                  slot_q        <= 2'd0;
                end
                default: slot_q <= 2'd0;
              endcase
            end
          end
          default: state_q <= HUNT;
        endcase
      end
    end
  end

  assign ch0         = ch0_q;
  assign ch1         = ch1_q;
  assign ch2         = ch2_q;
  assign ch3         = ch3_q;
  assign frame_valid = frame_valid_q;
  assign sync_err    = sync_err_q;
  assign locked      = (state_q == LOCKED);
  assign frame_count = frame_count_q;

endmodule

// File: tb/tb_tdm_demux4.sv
// tb/tb_tdm_demux4.sv - directed self-checking bench for tdm_demux4
module tb_tdm_demux4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [0:0] din = 1'b0;
  logic       din_valid = 1'b0;
  logic       sync = 1'b0;
  logic [0:0] ch0, ch1, ch2, ch3;
  logic       frame_valid, sync_err, locked;
  logic [7:0] frame_count;

  int n_checks = 0;
  int n_pass   = 0;

  tdm_demux4 #(.WIDTH(1), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .sync(sync),
    .ch0(ch0), .ch1(ch1), .ch2(ch2), .ch3(ch3),
    .frame_valid(frame_valid), .sync_err(sync_err), .locked(locked),
    .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [3:0] chans();
    return {ch0, ch1, ch2, ch3};
  endfunction

  // One isolated beat; outputs are sampled 1 time unit after the capturing edge.
  task automatic beat(input logic s, input logic d);
    @(negedge clk);
    din_valid = 1'b1;
    sync = s;
    din = d;
    @(posedge clk);
    #1;
    din_valid = 1'b0;
    sync = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  int fv_pulses;
  int err_pulses;

  initial begin
    // 1: reset and idle
    idle(3);
    @(negedge clk);
    rst = 1'b0;
    idle(2);
    check("rst_ch", {28'd0, chans()}, 32'h0);
    check("rst_fv", frame_valid, 0);
    check("rst_err", sync_err, 0);
    check("rst_locked", locked, 0);
    check("rst_cnt", frame_count, 0);

    // 2: basic frame 1,0,1,1
    beat(1, 1);
    check("f1_locked", locked, 1);
    beat(0, 0);
    beat(0, 1);
    check("f1_no_early_fv", frame_valid, 0);
    beat(0, 1);
    check("f1_ch", {28'd0, chans()}, 32'hB);
    check("f1_fv", frame_valid, 1);
    check("f1_cnt", frame_count, 1);
    check("f1_err", sync_err, 0);
    idle(1);
    check("f1_fv_drop", frame_valid, 0);

    // 3: same frame with gaps
    beat(1, 1); idle(2);
    beat(0, 0); idle(3);
    beat(0, 1); idle(2);
    check("f2_no_early_fv", frame_valid, 0);
    beat(0, 1);
    check("f2_ch", {28'd0, chans()}, 32'hB);
    check("f2_fv", frame_valid, 1);
    check("f2_cnt", frame_count, 2);

    // 4: early sync on slot 2
    beat(1, 0);
    beat(0, 1);
    beat(1, 0);
    check("es_err", sync_err, 1);
    check("es_fv", frame_valid, 0);
    check("es_ch_hold", {28'd0, chans()}, 32'hB);
    check("es_locked", locked, 1);
    beat(0, 1);
    check("es_err_drop", sync_err, 0);
    beat(0, 1);
    beat(0, 0);
    check("es_ch", {28'd0, chans()}, 32'h6);
    check("es_fv", frame_valid, 1);
    check("es_cnt", frame_count, 3);

    // 5: missing sync on slot 0
    beat(0, 1);
    check("ms_err", sync_err, 1);
    check("ms_locked", locked, 0);
    err_pulses = 0;
    fv_pulses = 0;
    for (int i = 0; i < 4; i++) begin
      beat(0, 1);
      err_pulses += int'(sync_err);
      fv_pulses += int'(frame_valid);
    end
    check("ms_hunt_err", err_pulses, 0);
    check("ms_hunt_fv", fv_pulses, 0);
    check("ms_hunt_locked", locked, 0);
    beat(1, 1); beat(0, 1); beat(0, 1); beat(0, 1);
    check("ms_relock_ch", {28'd0, chans()}, 32'hF);
    check("ms_relock_cnt", frame_count, 4);

    // 6: reset mid-frame, then wrap
    beat(1, 0); beat(0, 0); beat(0, 1);
    #2;
    rst = 1'b1;
    #1;
    check("mr_ch", {28'd0, chans()}, 32'h0);
    check("mr_cnt", frame_count, 0);
    check("mr_locked", locked, 0);
    @(negedge clk);
    rst = 1'b0;
    beat(0, 1);
    check("mr_needs_sync", locked, 0);

    fv_pulses = 0;
    err_pulses = 0;
    for (int f = 0; f < 256; f++) begin
      for (int s = 0; s < 4; s++) begin
        @(negedge clk);
        din_valid = 1'b1;
        sync = (s == 0);
        din = f[s];
        @(posedge clk);
        #1;
        fv_pulses += int'(frame_valid);
        err_pulses += int'(sync_err);
        if (s == 3 && f == 250) begin
          check("wr_ch250", {28'd0, chans()}, 32'h5);
          check("wr_cnt251", frame_count, 251);
        end
        if (s == 3 && f == 254) check("wr_cnt255", frame_count, 255);
      end
    end
    @(negedge clk);
    din_valid = 1'b0;
    check("wr_fv_pulses", fv_pulses, 256);
    check("wr_err_pulses", err_pulses, 0);
    check("wr_cnt_wrap", frame_count, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
